// File: rtl/seq_det_pkg.sv
// Shared constants for the serial sequence detector: FSM encoding, default
// widths and the configuration length limit.
package seq_det_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_DIV_W = 27;
  localparam int LEN_W     = 4;
  localparam int MAX_PAT_W = (1 << LEN_W) - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // A length is usable only if it selects at least one bit and fits the pattern.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
    return (len != '0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Sample-rate divider: pulses tick once every div+1 enabled cycles.
module seq_tick_gen #(
  parameter int DIV_W = 27
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = enable && (count == div);

  // Counter is held at zero while disabled so each RUN entry starts a fresh period.
  always_ff @(posedge Clock) begin
    if (Reset || !enable) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial sequence detector with a sampled input, optional
// overlapping matches and a saturating match counter.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             stop,
  input  logic             w,
  output logic             busy,
  output logic             z,
  output logic [7:0]       match_cnt,
  output logic             err
);

  logic [0:0]       state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [DIV_W-1:0] div_q;
  logic             ovl_q;
  logic             cfg_loaded;
  logic [PAT_W-1:0] shreg;
  logic [LEN_W-1:0] bits_seen;

  logic             tick;
  logic             run_tick;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] shift_next;
  logic [LEN_W-1:0] seen_inc;
  logic             is_match;

  assign busy      = (state == ST_RUN);
  assign cfg_ready = (state == ST_IDLE);

  seq_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .enable(busy),
    .div   (div_q),
    .tick  (tick)
  );

  // A tick on the stop cycle is dropped so no match can fire while leaving RUN.
  assign run_tick = tick && !stop;

  always_comb begin
    mask       = '0;
    shift_next = (shreg << 1) | PAT_W'(w);
    seen_inc   = (bits_seen < len_q) ? bits_seen + 1'b1 : bits_seen;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    is_match = run_tick && (seen_inc >= len_q) &&
               ((shift_next & mask) == (pat_q & mask));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      div_q      <= '0;
      ovl_q      <= 1'b0;
      cfg_loaded <= 1'b0;
      err        <= 1'b0;
      shreg      <= '0;
      bits_seen  <= '0;
      z          <= 1'b0;
      match_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          z <= 1'b0;
          if (cfg_valid) begin
            if (len_legal(cfg_len, PAT_W)) begin
              pat_q      <= cfg_pattern;
              len_q      <= cfg_len;
              div_q      <= cfg_div;
              ovl_q      <= cfg_overlap;
              cfg_loaded <= 1'b1;
              err        <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          if (start && !stop && cfg_loaded) begin
            state     <= ST_RUN;
            shreg     <= '0;
            bits_seen <= '0;
            match_cnt <= '0;
          end
        end
        default: begin
          z <= is_match;
          if (stop) begin
            state <= ST_IDLE;
          end
          if (run_tick) begin
            shreg     <= shift_next;
            bits_seen <= (is_match && !ovl_q) ? '0 : seen_inc;
          end
          if (is_match && (match_cnt != 8'hFF)) begin
            match_cnt <= match_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomized scoreboard bench for seq_det_ctrl: a queue-of-bits reference model
// predicts each z pulse (cycle and count); a monitor checks them as they appear.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int DIV_W = 27;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [3:0]       cfg_len = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_overlap = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             w = 1'b0;
  logic             busy;
  logic             z;
  logic [7:0]       match_cnt;
  logic             err;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  bit   stim_bits[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seq_det_ctrl #(.PAT_W(PAT_W), .DIV_W(DIV_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_div    (cfg_div),
    .cfg_overlap(cfg_overlap),
    .start      (start),
    .stop       (stop),
    .w          (w),
    .busy       (busy),
    .z          (z),
    .match_cnt  (match_cnt),
    .err        (err)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every z pulse must match the oldest predicted pulse.
  always @(negedge Clock) begin
    if (z) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_z_cycle", cyc, -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("z_cycle", cyc, e.cyc);
        checkOutput("z_match_cnt", match_cnt, e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout actual=%0d expected=0", cyc);
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic doCfg(input int pat, input int len, input int div, input bit ovl);
    cfg_pattern = PAT_W'(pat);
    cfg_len     = 4'(len);
    cfg_div     = DIV_W'(div);
    cfg_overlap = ovl;
    cfg_valid   = 1'b1;
    step();
    cfg_valid   = 1'b0;
  endtask

  // Runs stim_bits through the DUT under the given (already loaded) config and
  // predicts every match from the rule: last len samples equal the pattern.
  task automatic applyStimulus(input int pat, input int len, input int div, input bit ovl);
    bit hist[$];
    int exp_cnt;
    int entry;
    bit hit;
    exp_t e;
    exp_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    entry = cyc;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("cfg_ready_in_run", cfg_ready, 0);
    for (int k = 1; k <= stim_bits.size(); k++) begin
      w = stim_bits[k-1];
      hist.push_back(stim_bits[k-1]);
      if (hist.size() > len) void'(hist.pop_front());
      hit = (hist.size() == len);
      for (int j = 0; j < len && hit; j++) begin
        if (hist[len-1-j] != pat[j]) hit = 1'b0;
      end
      if (hit) begin
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        e.cyc = entry + k * (div + 1);
        e.cnt = exp_cnt;
        sb.push_back(e);
        if (!ovl) hist.delete();
      end
      repeat (div + 1) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checkOutput("busy_after_stop", busy, 0);
    step();
    checkOutput("pending_pulses", sb.size(), 0);
    checkOutput("match_cnt_held", match_cnt, exp_cnt);
    sb.delete();
  endtask

  task automatic loadBits(input int n, input bit val);
    stim_bits.delete();
    for (int i = 0; i < n; i++) stim_bits.push_back(val);
  endtask

  initial begin
    int pat, len, div, n;
    bit ovl;
    bit seq5[5];
    seq5 = '{1, 0, 1, 0, 1};
    repeat (3) step();
    Reset = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_cfg_ready", cfg_ready, 1);
    checkOutput("reset_z", z, 0);
    checkOutput("reset_match_cnt", match_cnt, 0);
    checkOutput("reset_err", err, 0);

    $display("[TB] start without configuration");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checkOutput("start_unloaded_busy", busy, 0);

    $display("[TB] pattern 0011, div 0");
    doCfg(8'h03, 4, 0, 1'b0);
    stim_bits = '{0, 0, 1, 1};
    applyStimulus(8'h03, 4, 0, 1'b0);

    $display("[TB] illegal lengths keep prior config");
    doCfg(8'h05, 3, 0, 1'b1);
    doCfg(8'hFF, 0, 2, 1'b0);
    checkOutput("err_len0", err, 1);
    doCfg(8'hFF, 9, 2, 1'b0);
    checkOutput("err_len9", err, 1);
    stim_bits.delete();
    foreach (seq5[i]) stim_bits.push_back(seq5[i]);
    applyStimulus(8'h05, 3, 0, 1'b1);
    doCfg(8'h05, 3, 0, 1'b0);
    checkOutput("err_cleared", err, 0);
    applyStimulus(8'h05, 3, 0, 1'b0);

    $display("[TB] divided sample rate");
    doCfg(8'h01, 1, 3, 1'b0);
    loadBits(6, 1'b1);
    applyStimulus(8'h01, 1, 3, 1'b0);

    $display("[TB] counter saturation");
    doCfg(8'h01, 1, 0, 1'b1);
    loadBits(300, 1'b1);
    applyStimulus(8'h01, 1, 0, 1'b1);
    checkOutput("match_cnt_saturated", match_cnt, 255);

    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    step();
    checkOutput("start_stop_same_cycle", busy, 0);

    $display("[TB] randomized configurations");
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(1, 4);
      pat = $urandom_range(0, 255);
      div = $urandom_range(0, 2);
      ovl = 1'($urandom_range(0, 1));
      n   = $urandom_range(20, 40);
      stim_bits.delete();
      for (int i = 0; i < n; i++) stim_bits.push_back(1'($urandom_range(0, 1)));
      doCfg(pat, len, div, ovl);
      applyStimulus(pat, len, div, ovl);
    end

    $display("[TB] reset during a matching tick");
    doCfg(8'h01, 1, 0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    w     = 1'b1;
    Reset = 1'b1;
    step();
    checkOutput("rst_run_z", z, 0);
    checkOutput("rst_run_busy", busy, 0);
    checkOutput("rst_run_match_cnt", match_cnt, 0);
    Reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checkOutput("rst_clears_cfg_loaded", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
